// File: rtl/fp_norm_pkg.sv
// fp_norm_pkg: shared constants and payload formats for the fraction normaliser
// Default configuration: 26-bit fraction, 8-bit biased exponent.
// The structs describe the stage payloads at the default widths; fp_norm_pipe
// re-declares the same layouts locally so that WIDTH/EXP_WIDTH can be overridden.
package fp_norm_pkg;
   localparam int FP_WIDTH     = 26;
   localparam int FP_EXP_WIDTH = 8;
   localparam int FP_SHAMT_W   = $clog2(FP_WIDTH);

   typedef struct packed {
      logic                    sign;
      logic [FP_EXP_WIDTH-1:0] exp;
      logic [FP_WIDTH-1:0]     frac;
      logic [FP_SHAMT_W-1:0]   lzc;
      logic                    zero;
   } s1_pay_t;

   typedef struct packed {
      logic                    sign;
      logic [FP_EXP_WIDTH-1:0] exp;
      logic [FP_WIDTH-1:0]     frac;
      logic [FP_SHAMT_W-1:0]   shamt;
      logic                    zero;
      logic                    denorm;
   } out_pay_t;
endpackage

// File: rtl/leading_zero_counter.sv
// leading_zero_counter: combinational leading-zero count by binary halving
// Ports:
//   i_data   - value to scan, MSB first
//   count    - number of leading zeros (0..WIDTH-1 for nonzero input)
//   all_zero - i_data is all zeros
module leading_zero_counter #(
   parameter int WIDTH = 26,
   localparam int CW = $clog2(WIDTH),
   localparam int P  = 1 << CW
) (
   input  logic [WIDTH-1:0] i_data,
   output logic [CW-1:0]    count,
   output logic             all_zero
);
   logic [P-1:0] w_v;

   // Zero padding at the LSB end keeps the count exact for non power-of-two
   // widths; each level inspects the upper half of the remaining window and
   // shifts it away when empty, giving a log2(WIDTH)-deep mux tree.
   always_comb begin
      w_v   = P'(i_data) << (P - WIDTH);
      count = '0;
      for (int k = CW - 1; k >= 0; k--) begin
         if ((w_v >> (P - (1 << k))) == '0) begin
            count[k] = 1'b1;
            w_v      = w_v << (1 << k);
         end
      end
      all_zero = ~w_v[P-1];
   end
endmodule

// File: rtl/fp_norm_pipe.sv
// fp_norm_pipe: two-stage valid/ready normaliser shifting the fraction MSB-up with exponent clamp
// Ports:
//   CLK, nRST            - clock, asynchronous active-low reset
//   in_valid / in_ready  - input handshake
//   sign_in, exp_in, frac_in - sign, biased exponent, unnormalised fraction
//   out_valid / out_ready - output handshake
//   sign_out, exp_out, frac_out - normalised result
//   shamt_out            - left shift applied
//   zero_out, denorm_out - fraction was zero / shift clamped by exponent
module fp_norm_pipe
   import fp_norm_pkg::*;
#(
   parameter int WIDTH     = FP_WIDTH,
   parameter int EXP_WIDTH = FP_EXP_WIDTH,
   parameter int SHAMT_W   = $clog2(WIDTH)
) (
   input  logic                 CLK,
   input  logic                 nRST,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 sign_in,
   input  logic [EXP_WIDTH-1:0] exp_in,
   input  logic [WIDTH-1:0]     frac_in,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 sign_out,
   output logic [EXP_WIDTH-1:0] exp_out,
   output logic [WIDTH-1:0]     frac_out,
   output logic [SHAMT_W-1:0]   shamt_out,
   output logic                 zero_out,
   output logic                 denorm_out
);
   localparam int CW = (EXP_WIDTH > SHAMT_W) ? EXP_WIDTH : SHAMT_W;

   typedef struct packed {
      logic                 sign;
      logic [EXP_WIDTH-1:0] exp;
      logic [WIDTH-1:0]     frac;
      logic [SHAMT_W-1:0]   lzc;
      logic                 zero;
   } s1_t;

   typedef struct packed {
      logic                 sign;
      logic [EXP_WIDTH-1:0] exp;
      logic [WIDTH-1:0]     frac;
      logic [SHAMT_W-1:0]   shamt;
      logic                 zero;
      logic                 denorm;
   } out_t;

   logic               r_s1_valid, r_s2_valid;
   s1_t                r_s1;
   out_t               r_s2;
   logic               w_s2_ready;
   logic [SHAMT_W-1:0] w_lzc;
   logic               w_zero;
   logic [CW-1:0]      w_lzc_e, w_exp_e;
   logic               w_clamp;
   out_t               w_res;

   leading_zero_counter #(.WIDTH(WIDTH)) u_lzc (
      .i_data   (frac_in),
      .count    (w_lzc),
      .all_zero (w_zero)
   );

   assign w_s2_ready = !r_s2_valid || out_ready;
   assign in_ready   = !r_s1_valid || w_s2_ready;

   // Compare at a common width so neither operand is truncated.
   assign w_lzc_e = CW'(r_s1.lzc);
   assign w_exp_e = CW'(r_s1.exp);
   assign w_clamp = w_lzc_e > w_exp_e;

   // A clamped shift only happens when exp < lzc <= WIDTH-1, so exp fits in SHAMT_W.
   always_comb begin
      w_res.sign   = r_s1.sign;
      w_res.zero   = r_s1.zero;
      w_res.denorm = !r_s1.zero && w_clamp;
      w_res.shamt  = r_s1.zero ? '0 : w_clamp ? SHAMT_W'(r_s1.exp) : r_s1.lzc;
      w_res.exp    = (r_s1.zero || w_clamp) ? '0 : EXP_WIDTH'(w_exp_e - w_lzc_e);
      w_res.frac   = r_s1.frac << w_res.shamt;
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_s1_valid <= 1'b0;
         r_s2_valid <= 1'b0;
         r_s1       <= '0;
         r_s2       <= '0;
      end else begin
         if (in_ready) r_s1_valid <= in_valid;
         if (in_valid && in_ready) r_s1 <= '{sign_in, exp_in, frac_in, w_lzc, w_zero};
         if (w_s2_ready) r_s2_valid <= r_s1_valid;
         if (r_s1_valid && w_s2_ready) r_s2 <= w_res;
      end
   end

   assign out_valid  = r_s2_valid;
   assign sign_out   = r_s2.sign;
   assign exp_out    = r_s2.exp;
   assign frac_out   = r_s2.frac;
   assign shamt_out  = r_s2.shamt;
   assign zero_out   = r_s2.zero;
   assign denorm_out = r_s2.denorm;
endmodule

// File: doc/fp_norm_pipe.md
Name: fp_norm_pipe

Overview:
Parametrised, pipelined normaliser for the FPU datapath, in the mantissa-normalisation slot after add/sub.
- Takes a sign/exponent/fraction triple and counts leading zeros.
- Left-shifts the fraction so its MSB is set, and decrements the exponent by the shift.
- Clamps at exponent zero, producing a denormal instead of a negative exponent.
- Two registered stages with valid/ready handshake; sustains one result per cycle under backpressure.

Parameters:
WIDTH, 26, fraction width in bits (>= 4).
EXP_WIDTH, 8, exponent width in bits.
SHAMT_W, $clog2(WIDTH), width of shift-amount output (derived; not overridden).

Ports:
CLK  in  1  clock, all state on rising edge.
nRST  in  1  asynchronous active-low reset.
in_valid  in  1  input triple valid.
in_ready  out  1  block can accept input this cycle.
sign_in  in  1  sign, passed through.
exp_in  in  EXP_WIDTH  biased exponent, unsigned.
frac_in  in  WIDTH  unnormalised fraction, MSB = hidden-bit position.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts result.
sign_out  out  1  sign, delayed.
exp_out  out  EXP_WIDTH  adjusted exponent.
frac_out  out  WIDTH  normalised fraction.
shamt_out  out  SHAMT_W  left-shift actually applied.
zero_out  out  1  frac_in was all zeros.
denorm_out  out  1  shift clamped by exponent; result subnormal.

Behaviour:
- Reset (nRST low, asynchronous):
  - Both stage valid bits clear; all output registers 0.
  - in_ready = 1 while the pipe is empty.
  - Reset mid-operation discards in-flight data; no partial result emerges after release.
- Handshake:
  - Transfer occurs on a cycle with valid && ready at the same edge.
  - s2_ready = !s2_valid || out_ready.
  - in_ready = !s1_valid || s2_ready (combinational; no combinational path from in_valid to in_ready).
  - Stage advances only when the next stage is ready.
  - Registers hold stable while out_valid && !out_ready; payload must not change until accepted.
- Latency: 2 cycles from input accept to out_valid with out_ready held high. Throughput: 1 per cycle. Order is preserved.
- Stage 1: registers sign, exp, frac, lzc = count of leading zeros of frac_in (0..WIDTH-1), and zero = (frac_in == 0).
- Stage 2 computes:
  - zero: shamt = 0, frac_out = 0, exp_out = 0, zero_out = 1, denorm_out = 0.
  - lzc <= exp: shamt = lzc, exp_out = exp - lzc, denorm_out = 0. lzc == exp gives exp_out = 0 with MSB set; this is not denorm.
  - lzc > exp: shamt = exp[SHAMT_W-1:0], exp_out = 0, denorm_out = 1. This requires exp < WIDTH, which is implied here.
  - frac_out = frac << shamt, zero-filled from the LSB; no bits are lost from the top.
- All arithmetic is unsigned. exp_out never wraps below 0.
- frac_in with MSB already set: shamt 0, outputs equal inputs.
- Simultaneous accept of a new input and drain of an output in the same cycle is legal and loses no bubble.

Decomposition:
- Package fp_norm_pkg:
  - default WIDTH/EXP_WIDTH constants.
  - stage-1 payload struct {sign, exp, frac, lzc, zero}.
  - output payload struct.
- Sub-module leading_zero_counter:
  - parameter WIDTH.
  - outputs count[$clog2(WIDTH)-1:0] and all_zero.
  - purely combinational, tree-structured; instantiated in stage 1.
- Shift and clamp logic stay inline in fp_norm_pipe.

Test Plan:
1. WIDTH=26, EXP_WIDTH=8: frac_in=26'h0800000, exp_in=100, sign=1 -> after 2 cycles frac_out=26'h2000000, exp_out=98, shamt_out=2, sign_out=1, zero/denorm=0.
2. frac_in=26'h0000001, exp_in=10 -> frac_out=26'h0000400, exp_out=0, shamt_out=10, denorm_out=1. Then frac_in=26'h0100000, exp_in=5 -> frac_out=26'h2000000, exp_out=0, shamt=5, denorm_out=0.
3. frac_in=0, exp_in=50 -> frac_out=0, exp_out=0, shamt=0, zero_out=1. Also frac_in=26'h2000001, exp_in=7 -> output unchanged, shamt=0.
4. Backpressure: out_ready=0, in_valid=1 streaming 3 distinct triples -> 2 accepted, in_ready=0 on the 3rd cycle, outputs stable. Release out_ready -> results emerge in order, one per cycle.
5. Streaming 100 random triples with out_ready=1 -> one result per cycle after a 2-cycle fill, matching the reference model, including WIDTH=48/EXP_WIDTH=11 builds.
6. nRST pulled low asynchronously mid-cycle with both stages full -> out_valid and all outputs 0 immediately, in_ready=1. After release, no stale result appears.
